// File: rtl/vec_strided_lsu.sv
// Strided vector load/store unit: walks base + i*stride, issuing one
// word-aligned memory transaction per element, extracting load bytes into
// the packed destination image and replicating store elements across lanes.
module vec_strided_lsu #(
    parameter int VLEN = 128
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [31:0]     req_base,
    input  logic [31:0]     req_stride,
    input  logic [7:0]      req_vl,
    input  logic [1:0]      req_sew,
    input  logic [VLEN-1:0] req_sdata,
    output logic            done,
    output logic            err,
    output logic [VLEN-1:0] rsp_data,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic [31:0]     mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            store_q, store_d;
    logic [31:0]     stride_q, stride_d;
    logic [31:0]     addr_q, addr_d;
    logic [7:0]      vl_q, vl_d;
    logic [7:0]      idx_q, idx_d;
    logic [1:0]      sew_q, sew_d;
    logic [VLEN-1:0] sdata_q, sdata_d;
    logic [VLEN-1:0] rsp_q, rsp_d;
    logic            err_q, err_d;

    // An address is unusable when it is not a multiple of the element size.
    function automatic logic misaligned(input logic [1:0] sew, input logic [1:0] a);
        return ((sew == 2'b01) && a[0]) || ((sew == 2'b10) && (a != 2'b00));
    endfunction

    logic [8:0]      req_vlmax;
    logic [15:0]     elem_shift;
    logic [31:0]     src_elem;
    logic [1:0]      lane;
    logic [31:0]     rdata_sh;
    logic [31:0]     load_elem;
    logic [31:0]     addr_next;
    logic [7:0]      idx_next;

    assign lane      = addr_q[1:0];
    assign addr_next = addr_q + stride_q;
    assign idx_next  = idx_q + 8'd1;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign rsp_data  = rsp_q;
    assign rdata_sh  = mem_rdata >> {lane, 3'b000};
    assign src_elem  = 32'(sdata_q >> elem_shift);

    // Element-width dependent helpers: VLMAX of the incoming request, bit
    // offset of the current element in the register image, and the load
    // element taken from its byte lane.
    always_comb begin
        req_vlmax  = 9'd0;
        elem_shift = 16'd0;
        load_elem  = rdata_sh;
        case (req_sew)
            2'b00:   req_vlmax = 9'(VLEN / 8);
            2'b01:   req_vlmax = 9'(VLEN / 16);
            2'b10:   req_vlmax = 9'(VLEN / 32);
            default: req_vlmax = 9'd0;
        endcase
        case (sew_q)
            2'b00: begin
                elem_shift = {5'b0, idx_q, 3'b000};
                load_elem  = {24'b0, rdata_sh[7:0]};
            end
            2'b01: begin
                elem_shift = {4'b0, idx_q, 4'b0000};
                load_elem  = {16'b0, rdata_sh[15:0]};
            end
            default: begin
                elem_shift = {3'b0, idx_q, 5'b00000};
                load_elem  = rdata_sh;
            end
        endcase
    end

    // Next-state and output decode of the IDLE/ISSUE/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        store_d   = store_q;
        stride_d  = stride_q;
        addr_d    = addr_q;
        vl_d      = vl_q;
        idx_d     = idx_q;
        sew_d     = sew_q;
        sdata_d   = sdata_q;
        rsp_d     = rsp_q;
        err_d     = err_q;
        req_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
        case (sew_q)
            2'b00:   mem_wdata = {4{src_elem[7:0]}};
            2'b01:   mem_wdata = {2{src_elem[15:0]}};
            default: mem_wdata = src_elem;
        endcase

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    store_d  = req_store;
                    stride_d = req_stride;
                    addr_d   = req_base;
                    vl_d     = req_vl;
                    sew_d    = req_sew;
                    sdata_d  = req_sdata;
                    idx_d    = 8'd0;
                    rsp_d    = '0;
                    if ((req_sew == 2'b11) || ({1'b0, req_vl} > req_vlmax) ||
                        misaligned(req_sew, req_base[1:0])) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (req_vl == 8'd0) begin
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                mem_valid = 1'b1;
                if (store_q) begin
                    case (sew_q)
                        2'b00:   mem_wstrb = 4'b0001 << lane;
                        2'b01:   mem_wstrb = 4'b0011 << lane;
                        default: mem_wstrb = 4'b1111;
                    endcase
                end
                if (mem_ready) begin
                    idx_d  = idx_next;
                    addr_d = addr_next;
                    if (!store_q) begin
                        rsp_d = rsp_q | ({{(VLEN-32){1'b0}}, load_elem} << elem_shift);
                    end
                    // The stepped address is checked even after the final
                    // element, so a misaligning stride is always reported.
                    if (misaligned(sew_q, addr_next[1:0])) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (idx_next == vl_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset back to an idle, empty unit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            store_q  <= 1'b0;
            stride_q <= 32'd0;
            addr_q   <= 32'd0;
            vl_q     <= 8'd0;
            idx_q    <= 8'd0;
            sew_q    <= 2'b00;
            sdata_q  <= '0;
            rsp_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            stride_q <= stride_d;
            addr_q   <= addr_d;
            vl_q     <= vl_d;
            idx_q    <= idx_d;
            sew_q    <= sew_d;
            sdata_q  <= sdata_d;
            rsp_q    <= rsp_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_vec_strided_lsu.sv
// Bench for vec_strided_lsu: directed table, reset-abort sequence and
// randomized requests checked against an address-list reference model.
module tb_vec_strided_lsu;

    localparam int VLEN = 128;

    logic            clk;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic            req_store;
    logic [31:0]     req_base;
    logic [31:0]     req_stride;
    logic [7:0]      req_vl;
    logic [1:0]      req_sew;
    logic [VLEN-1:0] req_sdata;
    logic            done;
    logic            err;
    logic [VLEN-1:0] rsp_data;
    logic            mem_valid;
    logic            mem_ready = 1'b0;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic [3:0]      mem_wstrb;
    logic [31:0]     mem_rdata = 32'd0;

    vec_strided_lsu #(.VLEN(VLEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_base   (req_base),
        .req_stride (req_stride),
        .req_vl     (req_vl),
        .req_sew    (req_sew),
        .req_sdata  (req_sdata),
        .done       (done),
        .err        (err),
        .rsp_data   (rsp_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Bench memory: 256 words, aliased on address bits [9:2].
    logic [31:0] mem [0:255];
    int          mem_lat = 1;
    int          wait_cnt = 0;
    int          vcnt = 0;
    logic [31:0] log_a[$];
    logic [31:0] log_d[$];
    logic [3:0]  log_s[$];
    logic        prev_v = 1'b0;
    logic        prev_rst = 1'b1;
    logic [31:0] prev_a = 32'd0;
    logic [31:0] prev_d = 32'd0;
    logic [3:0]  prev_s = 4'd0;

    // Expected access list produced by the reference model or the table.
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    logic [3:0]  exp_s[$];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Memory responder: answers mem_lat cycles after valid, at the negedge.
    always @(negedge clk) begin
        if (prev_v && !mem_ready && !reset && !prev_rst) begin
            checks++;
            if (!mem_valid || mem_addr !== prev_a || mem_wdata !== prev_d || mem_wstrb !== prev_s) begin
                errors++;
                $display("FAIL hold addr %h/%h wdata %h/%h wstrb %b/%b valid %b",
                         mem_addr, prev_a, mem_wdata, prev_d, mem_wstrb, prev_s, mem_valid);
            end
        end
        prev_v   = mem_valid;
        prev_a   = mem_addr;
        prev_d   = mem_wdata;
        prev_s   = mem_wstrb;
        prev_rst = reset;
        if (mem_valid) vcnt++;
        if (mem_ready) begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end
        if (!mem_valid) begin
            wait_cnt = 0;
        end else if (wait_cnt >= mem_lat) begin
            mem_rdata = mem[mem_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            log_a.push_back(mem_addr);
            log_d.push_back(mem_wdata);
            log_s.push_back(mem_wstrb);
            mem_ready = 1'b1;
        end else begin
            wait_cnt++;
        end
    end

    // Reference model: element i lives at base + i*stride; the walk stops
    // with an error at the first misaligned address (including the one
    // after the last element) and each element is handled byte by byte.
    task automatic model(input logic st, input logic [31:0] b, input logic [31:0] s,
                         input logic [7:0] v, input logic [1:0] w, input logic [127:0] sd,
                         output logic e, output logic [127:0] rsp);
        int          bytes;
        logic [31:0] a;
        logic [31:0] word;
        logic [31:0] wd;
        logic [3:0]  sb;
        exp_a.delete(); exp_d.delete(); exp_s.delete();
        e = 1'b0;
        rsp = '0;
        bytes = 1 << w;
        if (w == 2'b11 || int'(v) > VLEN / (8 * bytes)) begin
            e = 1'b1;
        end else begin
            for (int i = 0; i <= int'(v); i++) begin
                a = b + s * 32'(i);
                if (int'(a % 32'(bytes)) != 0) begin
                    e = 1'b1;
                    break;
                end
                if (i == int'(v)) break;
                word = mem[a[9:2]];
                wd = 32'd0;
                sb = 4'd0;
                for (int k = 0; k < 4; k++) begin
                    if (st) begin
                        if (k >= int'(a[1:0]) && k < int'(a[1:0]) + bytes) sb[k] = 1'b1;
                        wd[8*k +: 8] = sd[i*8*bytes + 8*(k % bytes) +: 8];
                    end else if (k < bytes) begin
                        rsp[i*8*bytes + 8*k +: 8] = word[8*(int'(a[1:0]) + k) +: 8];
                    end
                end
                exp_a.push_back({a[31:2], 2'b00});
                exp_d.push_back(wd);
                exp_s.push_back(sb);
            end
        end
    endtask

    task automatic run_req(input logic st, input logic [31:0] b, input logic [31:0] s,
                           input logic [7:0] v, input logic [1:0] w, input logic [127:0] sd,
                           input int lat, output int cyc, output logic got_done,
                           output logic got_err, output logic [127:0] got_rsp,
                           output logic busy_rdy, output logic after_rdy);
        @(negedge clk);
        mem_lat = lat;
        log_a.delete(); log_d.delete(); log_s.delete();
        vcnt = 0;
        req_store = st; req_base = b; req_stride = s; req_vl = v; req_sew = w;
        req_sdata = sd; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        busy_rdy = req_ready;
        cyc = 1;
        while (!done && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        got_done = done;
        got_err  = err;
        got_rsp  = rsp_data;
        @(posedge clk);
        #1;
        after_rdy = req_ready && !done;
    endtask

    // Run one request and compare everything against the expected queues.
    task automatic exec(input string tag, input logic st, input logic [31:0] b,
                        input logic [31:0] s, input logic [7:0] v, input logic [1:0] w,
                        input logic [127:0] sd, input int lat, input logic e_err,
                        input logic [127:0] e_rsp, input int e_cyc);
        int          cyc;
        logic        gd, ge, br, ar;
        logic [127:0] gr;
        run_req(st, b, s, v, w, sd, lat, cyc, gd, ge, gr, br, ar);
        $display("%s: store=%0d base=%h stride=%h vl=%0d sew=%0d err=%0d cycles=%0d accesses=%0d",
                 tag, st, b, s, v, w, ge, cyc, log_a.size());
        chk($sformatf("%s done", tag), 128'(gd), 128'(1'b1));
        chk($sformatf("%s err", tag), 128'(ge), 128'(e_err));
        chk($sformatf("%s rsp", tag), gr, e_rsp);
        chk($sformatf("%s cycles", tag), 128'(cyc), 128'(e_cyc));
        chk($sformatf("%s valid_cycles", tag), 128'(vcnt), 128'(exp_a.size() * (lat + 1)));
        chk($sformatf("%s naccess", tag), 128'(log_a.size()), 128'(exp_a.size()));
        for (int k = 0; k < exp_a.size() && k < log_a.size(); k++) begin
            chk($sformatf("%s addr[%0d]", tag, k), 128'(log_a[k]), 128'(exp_a[k]));
            chk($sformatf("%s wstrb[%0d]", tag, k), 128'(log_s[k]), 128'(exp_s[k]));
            if (st) chk($sformatf("%s wdata[%0d]", tag, k), 128'(log_d[k]), 128'(exp_d[k]));
        end
        chk($sformatf("%s busy_ready", tag), 128'(br), 128'(1'b0));
        chk($sformatf("%s idle_after", tag), 128'(ar), 128'(1'b1));
    endtask

    typedef struct {
        logic              st;
        logic [31:0]       base;
        logic [31:0]       stride;
        logic [7:0]        vl;
        logic [1:0]        sew;
        logic [127:0]      sdata;
        int                lat;
        logic              e_err;
        logic [127:0]      e_rsp;
        int                e_cyc;
        int                e_n;
        logic [3:0][31:0]  ea;
        logic [3:0][31:0]  ed;
        logic [3:0][3:0]   es;
    } vec_t;

    vec_t tv[8];

    task automatic run_vec(input int t);
        exp_a.delete(); exp_d.delete(); exp_s.delete();
        for (int k = 0; k < tv[t].e_n; k++) begin
            exp_a.push_back(tv[t].ea[k]);
            exp_d.push_back(tv[t].ed[k]);
            exp_s.push_back(tv[t].es[k]);
        end
        exec($sformatf("vec%0d", t), tv[t].st, tv[t].base, tv[t].stride, tv[t].vl, tv[t].sew,
             tv[t].sdata, tv[t].lat, tv[t].e_err, tv[t].e_rsp, tv[t].e_cyc);
    endtask

    initial begin
        logic        st, e;
        logic [1:0]  w;
        logic [7:0]  v;
        logic [31:0] b, s;
        logic [127:0] sd, rsp;
        int          bytes, vlmax, lat, stride_el, n;

        tv[0] = '{1'b0, 32'd400, 32'd4, 8'd4, 2'b10, 128'd0, 1, 1'b0,
                  128'h000f0e0d_0c0b0a09_08070605_04030201, 9, 4,
                  {32'd412, 32'd408, 32'd404, 32'd400}, '0, '0};
        tv[1] = '{1'b0, 32'd400, 32'd1, 8'd4, 2'b00, 128'd0, 1, 1'b0,
                  128'h04030201, 9, 4,
                  {32'd400, 32'd400, 32'd400, 32'd400}, '0, '0};
        tv[2] = '{1'b1, 32'd440, 32'd6, 8'd3, 2'b01, 128'h3333_2222_1111, 1, 1'b0,
                  128'd0, 7, 3,
                  {32'd0, 32'd452, 32'd444, 32'd440},
                  {32'd0, 32'h33333333, 32'h22222222, 32'h11111111},
                  {4'b0000, 4'b0011, 4'b1100, 4'b0011}};
        tv[3] = '{1'b0, 32'd412, 32'hFFFFFFFC, 8'd3, 2'b10, 128'd0, 1, 1'b0,
                  128'h08070605_0c0b0a09_000f0e0d, 7, 3,
                  {32'd0, 32'd404, 32'd408, 32'd412}, '0, '0};
        tv[4] = '{1'b0, 32'd402, 32'd4, 8'd1, 2'b10, 128'd0, 1, 1'b1, 128'd0, 1, 0, '0, '0, '0};
        tv[5] = '{1'b0, 32'd400, 32'd4, 8'd0, 2'b00, 128'd0, 1, 1'b0, 128'd0, 1, 0, '0, '0, '0};
        tv[6] = '{1'b0, 32'd400, 32'd4, 8'd5, 2'b10, 128'd0, 1, 1'b1, 128'd0, 1, 0, '0, '0, '0};
        tv[7] = '{1'b1, 32'd400, 32'd4, 8'd2, 2'b11, 128'd0, 1, 1'b1, 128'd0, 1, 0, '0, '0, '0};

        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        mem[100] = 32'h04030201;
        mem[101] = 32'h08070605;
        mem[102] = 32'h0c0b0a09;
        mem[103] = 32'h000f0e0d;

        reset = 1'b1;
        req_valid = 1'b0; req_store = 1'b0; req_base = '0; req_stride = '0;
        req_vl = '0; req_sew = '0; req_sdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready", 128'(req_ready), 128'(1'b1));
        chk("reset mem_valid", 128'(mem_valid), 128'(1'b0));
        chk("reset mem_wstrb", 128'(mem_wstrb), 128'(4'b0));
        chk("reset done", 128'(done), 128'(1'b0));
        chk("reset err", 128'(err), 128'(1'b0));
        chk("reset rsp_data", rsp_data, 128'd0);
        reset = 1'b0;

        for (int t = 0; t < 8; t++) run_vec(t);

        // Reset while the second of four elements is outstanding.
        @(negedge clk);
        mem_lat = 1;
        log_a.delete(); log_d.delete(); log_s.delete();
        req_store = 1'b0; req_base = 32'd400; req_stride = 32'd4; req_vl = 8'd4;
        req_sew = 2'b10; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (log_a.size() < 1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort first element", 128'(log_a.size() >= 1), 128'(1'b1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        $display("abort: reset applied, mem_valid=%0d req_ready=%0d", mem_valid, req_ready);
        chk("abort mem_valid", 128'(mem_valid), 128'(1'b0));
        chk("abort req_ready", 128'(req_ready), 128'(1'b1));
        chk("abort done", 128'(done), 128'(1'b0));
        reset = 1'b0;
        run_vec(0);

        for (int r = 0; r < 40; r++) begin
            st = 1'($urandom_range(0, 1));
            w = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            bytes = (w == 2'b11) ? 1 : (1 << w);
            vlmax = VLEN / (8 * bytes);
            v = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, vlmax + 2))
                                             : 8'($urandom_range(1, vlmax));
            b = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) != 0) b = b & ~32'(bytes - 1);
            stride_el = $urandom_range(0, 8) - 4;
            s = 32'(stride_el * bytes);
            if ($urandom_range(0, 7) == 0) s = s + 32'd1;
            sd = {$urandom(), $urandom(), $urandom(), $urandom()};
            lat = $urandom_range(0, 2);
            model(st, b, s, v, w, sd, e, rsp);
            exec($sformatf("rnd%0d", r), st, b, s, v, w, sd, lat, e, rsp,
                 exp_a.size() * (lat + 1) + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_strided_lsu.md
# vec_strided_lsu

Strided vector load/store unit for the vector coprocessor's memory port. It accepts one decoded `vlse.v` / `vsse.v` request (base, stride, vl, SEW), issues one memory transaction per element at `base + i*stride`, and performs byte-lane extraction and insertion. For loads it returns the packed destination register image; for stores it consumes the packed source register image. It sits directly between the coprocessor's decode/register-file stage and the shared memory valid/ready port.

## Interface
- `VLEN`, default 128: vector register width in bits. VLMAX = VLEN/SEW.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit idle; a request is accepted when `req_valid && req_ready`.
- `req_store`  in  1: 1 = strided store, 0 = strided load.
- `req_base`  in  32: byte address of element 0.
- `req_stride`  in  32: signed byte stride, two's complement.
- `req_vl`  in  8: element count.
- `req_sew`  in  2: element width; 00 = 8, 01 = 16, 10 = 32, 11 = illegal.
- `req_sdata`  in  VLEN: store source register; element i is at `[i*SEW +: SEW]`.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: valid with `done`; request rejected or aborted.
- `rsp_data`  out  VLEN: load result, packed like `req_sdata`.
- `mem_valid`  out  1: memory request.
- `mem_ready`  in  1: memory completion, one cycle wide; `mem_rdata` is valid in that cycle.
- `mem_addr`  out  32: word-aligned address (`[1:0]` = 0).
- `mem_wdata`  out  32, `mem_wstrb`  out  4, `mem_rdata`  in  32: data and byte strobes; `mem_wstrb` is 0 for loads.

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE:
  - `req_ready` = 1.
  - On accept, latch all request fields, clear `rsp_data` to 0, set element index i = 0, and set address accumulator A = `req_base`.
- Accept-time checks:
  - If SEW = 11, or vl > VLMAX, or the base is misaligned for the element width, go to DONE with `err` = 1 and issue no access.
  - Misaligned means: SEW16 with `base[0]` = 1; SEW32 with `base[1:0]` ≠ 0.
  - If vl = 0, go to DONE with `err` = 0 and issue no access.
  - Otherwise go to ISSUE.
- ISSUE:
  - `mem_valid` = 1, `mem_addr` = {A[31:2], 2'b00}, lane = A[1:0].
  - Loads: SEW8 takes byte `rdata[lane*8 +: 8]`; SEW16 takes `rdata[lane*8 +: 16]`; SEW32 takes all of `rdata`. The element is written into `rsp_data[i*SEW +: SEW]` on `mem_ready`.
  - Stores: `mem_wdata` = element replicated across the word (SEW8 ×4, SEW16 ×2). `mem_wstrb` = 0001<<lane (SEW8), 0011<<lane (SEW16), or 1111 (SEW32).
  - On `mem_ready`: i ← i+1 and A ← A + stride (32-bit wrap-around).
  - If the new A is misaligned for SEW, go to DONE with `err` = 1; the elements already transferred stand.
  - If i+1 = vl, go to DONE.
- DONE: `done` = 1 for one cycle, then return to IDLE.
- `rsp_data` holds its value until the next accept. Tail elements (index ≥ vl) read as 0.
- Element address arithmetic is modulo 2^32; a negative stride decrements A.

## Timing
- Reset values: `req_ready` = 1, `mem_valid` = 0, `mem_wstrb` = 0, `done` = 0, `err` = 0, `rsp_data` = 0, state = IDLE.
- Reset asserted mid-transfer: the unit is in IDLE and `mem_valid` = 0 in the cycle after the reset edge. No further accesses are issued; writes already accepted by memory are not undone.
- `mem_valid` rises the cycle after accept.
- `mem_valid` is held, and `mem_addr`/`mem_wdata`/`mem_wstrb` are stable, until `mem_ready` is sampled.
- The next element's address/data appear in the cycle after `mem_ready`. `mem_valid` stays high between elements.
- `mem_valid` drops in the cycle after the last `mem_ready`, which is also the `done` cycle.
- With memory that responds one cycle after valid: 2 cycles per element, so `done` occurs 2·vl+1 cycles after accept.
- Error or vl = 0 at accept: `done` occurs the cycle after accept.
- `req_ready` = 0 from the cycle after accept through the DONE cycle.

## Test plan
- Load, SEW32, base 400, stride 4, vl 4, with memory[100..103] = 04030201, 08070605, 0c0b0a09, 000f0e0d:
  - `mem_addr` = 400, 404, 408, 412.
  - `rsp_data[127:0]` = 000f0e0d_0c0b0a09_08070605_04030201, `err` = 0.
  - `done` occurs 9 cycles after accept.
- Load, SEW8, base 400, stride 1, vl 4: `mem_addr` = 400 four times; `rsp_data[31:0]` = 04030201; `rsp_data[127:32]` = 0.
- Store, SEW16, base 440, stride 6, vl 3, `req_sdata[47:0]` = 3333_2222_1111:
  - (addr, wstrb, wdata) = (440, 0011, 11111111), (444, 1100, 22222222), (452, 0011, 33333333).
- Load, SEW32, base 412, stride −4 (FFFFFFFC), vl 3: `mem_addr` = 412, 408, 404; `rsp_data[95:0]` = 08070605_0c0b0a09_000f0e0d.
- Rejected requests:
  - SEW32 base 402 → `done` and `err` = 1 the cycle after accept, `mem_valid` never asserted.
  - vl = 0 → `done` with `err` = 0, no access.
  - vl = 5 with SEW32 → `err` = 1.
- Reset mid-transfer: assert `reset` while element 2 of 4 is pending → `mem_valid` = 0 and `req_ready` = 1 next cycle; a new request then completes normally.
